// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and widths for the memory arbiter
//
// Purpose : FSM state encoding, owner encoding, line and line-address widths
//           used by mem_arbiter and mem_arb_prio.
// Ports   : none (package).

package mem_arb_pkg;

    localparam int LINE_BITS      = 128;
    localparam int LINE_ADDR_BITS = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_WB  = 2'd0,
        OWN_DC  = 2'd1,
        OWN_PTW = 2'd2,
        OWN_IC  = 2'd3
    } owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - fixed-priority winner pick with IC starvation override
//
// Purpose : Combinational winner select (WB > DC > PTW > IC) plus a counter of
//           non-IC grants made while the IC is waiting; once the counter hits
//           STARVE_LIMIT the IC wins the next arbitration.
// Ports   : clk, rst      - clock, async active-low reset
//           grant         - arbitration is being committed this cycle
//           wb_req/dc_req/ptw_req/ic_req - requester levels
//           any_req       - at least one request is pending
//           winner        - selected owner for this cycle

module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   grant,
    input  logic   wb_req,
    input  logic   dc_req,
    input  logic   ptw_req,
    input  logic   ic_req,
    output logic   any_req,
    output owner_t winner
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;
    logic          starved;

    assign starved = ic_req && (starve_cnt == CW'(STARVE_LIMIT));

    always_comb begin
        any_req = wb_req | dc_req | ptw_req | ic_req;
        winner  = OWN_IC;
        if (starved)      winner = OWN_IC;
        else if (wb_req)  winner = OWN_WB;
        else if (dc_req)  winner = OWN_DC;
        else if (ptw_req) winner = OWN_PTW;
        else              winner = OWN_IC;
    end

    // Counter saturates at the limit; it only matters while the IC keeps asking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!ic_req) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (winner == OWN_IC)
                starve_cnt <= '0;
            else if (starve_cnt != CW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - four-requester arbiter in front of a line-wide backing memory
//
// Purpose : Serialises IC fetch, D-cache fill, D-cache write-back and PTW word
//           reads onto one backing-memory port, one transaction at a time.
// Ports   : clk, rst                         - clock, async active-low reset
//           Ic_mem_*  / F_mem_*              - IC line read
//           Dc_mem_*  / MEM_*                - D-cache line fill
//           Dc_wb_*                          - D-cache line write-back
//           Ptw_mem_*                        - PTW word read (byte address)
//           Arb_*                            - backing-memory request/response

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int PC_BITS      = 20,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Ic_mem_req,
    input  logic [PC_BITS-5:0]   Ic_mem_addr,
    output logic [LINE_BITS-1:0] F_mem_inst,
    output logic                 F_mem_valid,
    input  logic                 Dc_mem_req,
    input  logic [PC_BITS-5:0]   Dc_mem_addr,
    output logic [LINE_BITS-1:0] MEM_data_line,
    output logic                 MEM_mem_valid,
    input  logic                 Dc_wb_we,
    input  logic [PC_BITS-5:0]   Dc_wb_addr,
    input  logic [LINE_BITS-1:0] Dc_wb_wline,
    output logic                 Dc_wb_done,
    input  logic                 Ptw_mem_req,
    input  logic [PC_BITS-1:0]   Ptw_mem_addr,
    output logic [XLEN-1:0]      Ptw_mem_rdata,
    output logic                 Ptw_mem_valid,
    output logic                 Arb_req,
    output logic                 Arb_we,
    output logic [PC_BITS-5:0]   Arb_addr,
    output logic [LINE_BITS-1:0] Arb_wline,
    input  logic [LINE_BITS-1:0] Arb_rline,
    input  logic                 Arb_valid
);

    localparam int WORDS     = LINE_BITS / XLEN;
    localparam int WI_BITS   = (WORDS < 2) ? 1 : $clog2(WORDS);
    localparam int BYTE_BITS = $clog2(XLEN / 8);

    state_t                state, state_next;
    owner_t                owner, winner;
    logic                  any_req;
    logic                  grant;
    logic                  accept;
    logic [WI_BITS-1:0]    ptw_word;
    logic [LINE_BITS-1:0]  resp_line;
    logic                  unused_ptw_lsb;

    // Byte offset inside the PTW word has no meaning at line granularity.
    assign unused_ptw_lsb = ^Ptw_mem_addr[BYTE_BITS-1:0];

    assign grant  = (state == ST_IDLE) && any_req;
    // Responses are only meaningful while a grant is outstanding; anything
    // else (stale data after reset, spurious pulses) is dropped.
    assign accept = ((state == ST_ISSUE) || (state == ST_WAIT)) && Arb_valid;

    mem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk     (clk),
        .rst     (rst),
        .grant   (grant),
        .wb_req  (Dc_wb_we),
        .dc_req  (Dc_mem_req),
        .ptw_req (Ptw_mem_req),
        .ic_req  (Ic_mem_req),
        .any_req (any_req),
        .winner  (winner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next    = state;
        Arb_req       = 1'b0;
        F_mem_valid   = 1'b0;
        MEM_mem_valid = 1'b0;
        Dc_wb_done    = 1'b0;
        Ptw_mem_valid = 1'b0;
        case (state)
            ST_IDLE:  if (any_req) state_next = ST_ISSUE;
            ST_ISSUE: begin
                Arb_req    = 1'b1;
                state_next = Arb_valid ? ST_RESP : ST_WAIT;
            end
            ST_WAIT:  if (Arb_valid) state_next = ST_RESP;
            ST_RESP: begin
                state_next = ST_IDLE;
                case (owner)
                    OWN_WB:  Dc_wb_done    = 1'b1;
                    OWN_DC:  MEM_mem_valid = 1'b1;
                    OWN_PTW: Ptw_mem_valid = 1'b1;
                    OWN_IC:  F_mem_valid   = 1'b1;
                    default: ;
                endcase
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner         <= OWN_WB;
            Arb_we        <= 1'b0;
            Arb_addr      <= '0;
            Arb_wline     <= '0;
            ptw_word      <= '0;
            resp_line     <= '0;
            Ptw_mem_rdata <= '0;
        end else begin
            if (grant) begin
                owner     <= winner;
                Arb_we    <= (winner == OWN_WB);
                Arb_wline <= (winner == OWN_WB) ? Dc_wb_wline : '0;
                ptw_word  <= Ptw_mem_addr[BYTE_BITS +: WI_BITS];
                case (winner)
                    OWN_WB:  Arb_addr <= Dc_wb_addr;
                    OWN_DC:  Arb_addr <= Dc_mem_addr;
                    OWN_PTW: Arb_addr <= Ptw_mem_addr[PC_BITS-1:4];
                    default: Arb_addr <= Ic_mem_addr;
                endcase
            end
            if (accept) begin
                resp_line <= Arb_rline;
                if (owner == OWN_PTW)
                    Ptw_mem_rdata <= Arb_rline[int'(ptw_word) * XLEN +: XLEN];
            end
        end
    end

    assign F_mem_inst    = resp_line;
    assign MEM_data_line = resp_line;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter

module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int L    = 3;
    localparam int K_IC = 0;
    localparam int K_DC = 1;
    localparam int K_WB = 2;
    localparam int K_PT = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         Ic_mem_req, Dc_mem_req, Dc_wb_we, Ptw_mem_req;
    logic [15:0]  Ic_mem_addr, Dc_mem_addr, Dc_wb_addr;
    logic [19:0]  Ptw_mem_addr;
    logic [127:0] Dc_wb_wline;
    logic [127:0] F_mem_inst, MEM_data_line, Arb_wline, Arb_rline;
    logic         F_mem_valid, MEM_mem_valid, Dc_wb_done, Ptw_mem_valid;
    logic [31:0]  Ptw_mem_rdata;
    logic         Arb_req, Arb_we, Arb_valid;
    logic [15:0]  Arb_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.XLEN(32), .PC_BITS(20), .STARVE_LIMIT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .Ic_mem_req    (Ic_mem_req),
        .Ic_mem_addr   (Ic_mem_addr),
        .F_mem_inst    (F_mem_inst),
        .F_mem_valid   (F_mem_valid),
        .Dc_mem_req    (Dc_mem_req),
        .Dc_mem_addr   (Dc_mem_addr),
        .MEM_data_line (MEM_data_line),
        .MEM_mem_valid (MEM_mem_valid),
        .Dc_wb_we      (Dc_wb_we),
        .Dc_wb_addr    (Dc_wb_addr),
        .Dc_wb_wline   (Dc_wb_wline),
        .Dc_wb_done    (Dc_wb_done),
        .Ptw_mem_req   (Ptw_mem_req),
        .Ptw_mem_addr  (Ptw_mem_addr),
        .Ptw_mem_rdata (Ptw_mem_rdata),
        .Ptw_mem_valid (Ptw_mem_valid),
        .Arb_req       (Arb_req),
        .Arb_we        (Arb_we),
        .Arb_addr      (Arb_addr),
        .Arb_wline     (Arb_wline),
        .Arb_rline     (Arb_rline),
        .Arb_valid     (Arb_valid)
    );

    typedef struct {
        int           kind;
        logic [127:0] data;
        int           cyc;
    } pulse_t;

    typedef struct {
        logic [15:0]  addr;
        logic         we;
        logic [127:0] wline;
        int           cyc;
    } arb_t;

    pulse_t pq[$];
    arb_t   aq[$];
    int     vectors     = 0;
    int     miscompares = 0;
    int     cyc         = 0;
    int     arb_seen    = 0;
    int     pulse_seen  = 0;
    bit     outstanding = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] line_of(input logic [15:0] a);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = {a, 8'(i), 8'h5A};
        return r;
    endfunction

    function automatic bit pulse_of(input int k);
        case (k)
            K_IC:    return F_mem_valid;
            K_DC:    return MEM_mem_valid;
            K_WB:    return Dc_wb_done;
            default: return Ptw_mem_valid;
        endcase
    endfunction

    // Backing memory: answers every Arb_req with Arb_valid L cycles later.
    initial begin
        int          mcnt;
        logic [15:0] maddr;
        mcnt      = 0;
        maddr     = '0;
        Arb_valid = 1'b0;
        Arb_rline = '0;
        forever begin
            @(negedge clk);
            Arb_valid = 1'b0;
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    Arb_valid = 1'b1;
                    Arb_rline = line_of(maddr);
                end
            end
            if (Arb_req) begin
                mcnt  = L;
                maddr = Arb_addr;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT issues or completes.
    always @(negedge clk) begin
        arb_t         a;
        pulse_t       e;
        int           np;
        int           k;
        logic [127:0] d;
        bit           bad;
        if (!rst) begin
            outstanding = 0;
        end else begin
            if (Arb_req) begin
                arb_seen++;
                vectors++;
                bad = 0;
                if (outstanding) begin
                    bad = 1;
                    $display("FAIL arb_overlap actual=second Arb_req required=RESP first (cycle %0d)", cyc);
                end
                outstanding = 1;
                if (aq.size() == 0) begin
                    bad = 1;
                    $display("FAIL arb_unexpected actual addr=%h we=%b required=no request", Arb_addr, Arb_we);
                end else begin
                    a = aq.pop_front();
                    if (Arb_addr !== a.addr || Arb_we !== a.we || (a.we && Arb_wline !== a.wline) ||
                        (a.cyc >= 0 && cyc != a.cyc)) begin
                        bad = 1;
                        $display("FAIL arb_req actual addr=%h we=%b wline=%h cyc=%0d required addr=%h we=%b wline=%h cyc=%0d",
                                 Arb_addr, Arb_we, Arb_wline, cyc, a.addr, a.we, a.wline, a.cyc);
                    end
                end
                if (bad) miscompares++;
            end
            np = int'(F_mem_valid) + int'(MEM_mem_valid) + int'(Dc_wb_done) + int'(Ptw_mem_valid);
            if (np > 0) begin
                pulse_seen++;
                vectors++;
                outstanding = 0;
                k = F_mem_valid ? K_IC : MEM_mem_valid ? K_DC : Dc_wb_done ? K_WB : K_PT;
                d = (k == K_IC) ? F_mem_inst : (k == K_DC) ? MEM_data_line :
                    (k == K_PT) ? {96'b0, Ptw_mem_rdata} : 128'b0;
                if (np > 1) begin
                    miscompares++;
                    $display("FAIL pulse_multi actual=%0d pulses required=1", np);
                end else if (pq.size() == 0) begin
                    miscompares++;
                    $display("FAIL pulse_unexpected actual kind=%0d required=no pulse", k);
                end else begin
                    e = pq.pop_front();
                    if (k != e.kind || d !== e.data || (e.cyc >= 0 && cyc != e.cyc)) begin
                        miscompares++;
                        $display("FAIL pulse actual kind=%0d data=%h cyc=%0d required kind=%0d data=%h cyc=%0d",
                                 k, d, cyc, e.kind, e.data, e.cyc);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_pulse(input int kind);
        bit ok;
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (pulse_of(kind)) ok = 1;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_pulse kind=%0d actual=no pulse required=pulse within 60 cycles", kind);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_arb(input logic [15:0] a, input logic we, input logic [127:0] wl, input int c);
        arb_t x;
        x.addr = a; x.we = we; x.wline = wl; x.cyc = c;
        aq.push_back(x);
    endtask

    task automatic push_pulse(input int k, input logic [127:0] d, input int c);
        pulse_t x;
        x.kind = k; x.data = d; x.cyc = c;
        pq.push_back(x);
    endtask

    initial begin
        int t0;
        int snap_a;
        int snap_p;
        logic [127:0] wl;
        wl           = 128'hDEADBEEF_01234567_89ABCDEF_F00DCAFE;
        Ic_mem_req   = 0; Dc_mem_req = 0; Dc_wb_we = 0; Ptw_mem_req = 0;
        Ic_mem_addr  = '0; Dc_mem_addr = '0; Dc_wb_addr = '0;
        Ptw_mem_addr = '0; Dc_wb_wline = '0;

        repeat (3) step();
        check("rst_arb_req",   128'(Arb_req),       128'd0);
        check("rst_arb_we",    128'(Arb_we),        128'd0);
        check("rst_arb_addr",  128'(Arb_addr),      128'd0);
        check("rst_arb_wline", Arb_wline,           128'd0);
        check("rst_pulses",    128'({F_mem_valid, MEM_mem_valid, Dc_wb_done, Ptw_mem_valid}), 128'd0);
        check("rst_f_inst",    F_mem_inst,          128'd0);
        check("rst_ptw_rdata", 128'(Ptw_mem_rdata), 128'd0);
        rst = 1;
        repeat (2) step();

        // IC read, latency anchored to the request cycle
        t0 = cyc;
        push_arb(16'h0012, 1'b0, '0, t0 + 1);
        push_pulse(K_IC, line_of(16'h0012), t0 + 2 + L);
        Ic_mem_addr = 16'h0012; Ic_mem_req = 1;
        wait_pulse(K_IC);
        step(); Ic_mem_req = 0;
        repeat (2) step();

        // write-back and fill of the same miss arrive together
        push_arb(16'h0040, 1'b1, wl, -1);
        push_pulse(K_WB, '0, -1);
        push_arb(16'h0041, 1'b0, '0, -1);
        push_pulse(K_DC, line_of(16'h0041), -1);
        Dc_wb_addr = 16'h0040; Dc_wb_wline = wl; Dc_wb_we = 1;
        Dc_mem_addr = 16'h0041; Dc_mem_req = 1;
        wait_pulse(K_WB);
        step(); Dc_wb_we = 0;
        wait_pulse(K_DC);
        step(); Dc_mem_req = 0;
        repeat (2) step();

        // PTW word 2 of line 0x00A3
        push_arb(16'h00A3, 1'b0, '0, -1);
        push_pulse(K_PT, 128'h00A3025A, -1);
        Ptw_mem_addr = 20'h00A38; Ptw_mem_req = 1;
        wait_pulse(K_PT);
        step(); Ptw_mem_req = 0;
        repeat (2) step();

        // IC starvation: four DC grants, then IC wins
        for (int i = 0; i < 4; i++) begin
            push_arb(16'h0100, 1'b0, '0, -1);
            push_pulse(K_DC, line_of(16'h0100), -1);
        end
        push_arb(16'h0200, 1'b0, '0, -1);
        push_pulse(K_IC, line_of(16'h0200), -1);
        Dc_mem_addr = 16'h0100; Dc_mem_req = 1;
        Ic_mem_addr = 16'h0200; Ic_mem_req = 1;
        for (int i = 0; i < 4; i++) wait_pulse(K_DC);
        wait_pulse(K_IC);
        step(); Dc_mem_req = 0; Ic_mem_req = 0;
        repeat (2) step();

        // reset while waiting on memory; the late response must be dropped
        t0 = cyc;
        push_arb(16'h0300, 1'b0, '0, t0 + 1);
        Ic_mem_addr = 16'h0300; Ic_mem_req = 1;
        step(); step();
        snap_p = pulse_seen;
        rst = 0; Ic_mem_req = 0;
        #1;
        check("midrst_arb_addr", 128'(Arb_addr), 128'd0);
        check("midrst_arb_req",  128'(Arb_req),  128'd0);
        step(); rst = 1;
        repeat (6) step();
        check("midrst_no_pulse", 128'(pulse_seen - snap_p), 128'd0);
        t0 = cyc;
        push_arb(16'h0034, 1'b0, '0, t0 + 1);
        push_pulse(K_IC, line_of(16'h0034), t0 + 2 + L);
        Ic_mem_addr = 16'h0034; Ic_mem_req = 1;
        wait_pulse(K_IC);
        step(); Ic_mem_req = 0;
        repeat (2) step();

        // quiet period
        snap_a = arb_seen;
        snap_p = pulse_seen;
        repeat (20) step();
        check("idle_arb_req", 128'(arb_seen - snap_a),   128'd0);
        check("idle_pulses",  128'(pulse_seen - snap_p), 128'd0);

        check("arb_queue_empty",   128'(aq.size()), 128'd0);
        check("pulse_queue_empty", 128'(pq.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data word width.
REQ-002 SHALL have parameter PC_BITS, default 20, physical byte-address width; line address is PC_BITS-4 = 16 bits.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, number of consecutive non-IC grants tolerated while IC waits.
REQ-004 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset). rst is asynchronous and active-low.
REQ-005 SHALL have IC read port: Ic_mem_req in 1, Ic_mem_addr in 16 (line address), F_mem_inst out 128, F_mem_valid out 1.
REQ-006 SHALL have D-cache fill port: Dc_mem_req in 1, Dc_mem_addr in 16, MEM_data_line out 128, MEM_mem_valid out 1.
REQ-007 SHALL have D-cache write-back port: Dc_wb_we in 1, Dc_wb_addr in 16, Dc_wb_wline in 128, Dc_wb_done out 1.
REQ-008 SHALL have PTW word port: Ptw_mem_req in 1, Ptw_mem_addr in 20 (byte address), Ptw_mem_rdata out 32, Ptw_mem_valid out 1.
REQ-009 SHALL have backing-memory port: Arb_req out 1, Arb_we out 1, Arb_addr out 16, Arb_wline out 128, Arb_rline in 128, Arb_valid in 1.

Function
REQ-010 Requests SHALL be level-held by requesters until their valid/done pulse; requesters SHALL drop the request in the cycle after the pulse.
REQ-011 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-012 IDLE: if any request is high, the arbiter SHALL pick a winner, register owner, Arb_addr, Arb_we and Arb_wline, and move to ISSUE; otherwise it SHALL stay in IDLE.
REQ-013 Priority SHALL be WB > DC fill > PTW > IC, so a dirty eviction precedes the fill of the same miss.
REQ-014 Starvation override: the arbiter SHALL count grants to non-IC owners while Ic_mem_req is high; at count == STARVE_LIMIT, IC SHALL win the next arbitration. The count SHALL clear on an IC grant or when Ic_mem_req is low.
REQ-015 ISSUE SHALL last exactly one cycle with Arb_req = 1, then move to WAIT. Arb_req SHALL be 0 in all other states.
REQ-016 Arb_valid SHALL be accepted in ISSUE or WAIT. On acceptance the arbiter SHALL latch Arb_rline into a response register and move to RESP.
REQ-017 RESP SHALL last one cycle, pulse exactly the owner's valid/done output, then return to IDLE. Write grants SHALL also complete on Arb_valid.
REQ-018 PTW data SHALL be the word Ptw_mem_addr[3:2] of the line, with word 0 at bits [31:0]. Arb_addr for a PTW grant SHALL be Ptw_mem_addr[19:4].
REQ-019 Latency: a request sampled in IDLE at cycle t SHALL raise Arb_req at t+1. With the memory asserting Arb_valid at t+1+L, the owner pulse SHALL occur at t+2+L.
REQ-020 Arb_valid in IDLE or RESP SHALL be ignored, including stale responses after reset.
REQ-021 Request changes during ISSUE, WAIT or RESP SHALL NOT alter the registered grant. Arbitration SHALL occur only in IDLE.
REQ-022 Response data outputs SHALL hold their last value. Consumers SHALL qualify them by the valid pulse only.

Reset
REQ-023 On rst low, asynchronously: state = IDLE, starve count = 0, and Arb_req, Arb_we, all valid/done outputs = 0. Arb_addr, Arb_wline and response data SHALL be 0.
REQ-024 Reset mid-transaction SHALL abandon the grant with no pulse to any requester. After release, arbitration SHALL restart from IDLE.

Structure
REQ-025 A shared package mem_arb_pkg SHALL hold the FSM state encoding, owner encoding (OWN_WB, OWN_DC, OWN_PTW, OWN_IC), LINE_BITS = 128, and line-address width.
REQ-026 Winner selection with starvation override SHALL be a sub-module mem_arb_prio (combinational pick plus starve counter). All other logic SHALL stay in mem_arbiter.

Verification
REQ-027 Memory model with L=3. Ic_mem_req=1, addr 0x0012 at cycle 0 -> Arb_req cycle 1 with Arb_addr 0x0012, Arb_we 0; F_mem_valid pulse at cycle 5 carrying the model line.
REQ-028 Dc_wb_we and Dc_mem_req rise together (addr 0x0040, 0x0041) -> write to 0x0040 with Arb_we=1 first and Dc_wb_done pulse; then read of 0x0041 and MEM_mem_valid pulse; never two Arb_req pulses without an intervening RESP.
REQ-029 Ptw_mem_addr 0x0A38 with line words W0..W3 -> Arb_addr 0x00A3; Ptw_mem_rdata = W2 with Ptw_mem_valid pulse.
REQ-030 Ic_mem_req held high while Dc_mem_req is continuously re-requested -> IC granted after exactly 4 DC grants.
REQ-031 rst asserted in WAIT, then Arb_valid arrives after release -> no valid/done pulse; next IC request serviced normally with the REQ-019 latency.
REQ-032 No requests for 20 cycles -> Arb_req stays 0 and all pulses stay 0.
